// File: rtl/el2_ifu_fb_aln_if.sv
// Fetch-packet and decode handshake bundle for the fetch buffer / aligner.
// master: fetch control + decode side (drives packets, flush, decode accept)
// slave : the aligner itself
interface el2_ifu_fb_aln_if;
   logic          ifu_fetch_val;
   logic [63:0]   ifu_fetch_data;
   logic [30:0]   ifu_fetch_pc;
   logic [3:0]    ifu_fetch_hw_val;
   logic          ifu_fetch_acc_err;
   logic          exu_flush_final;
   logic          dec_i0_decode_d;

   logic          ifu_i0_valid;
   logic [31:0]   ifu_i0_instr;
   logic [30:0]   ifu_i0_pc;
   logic          ifu_i0_pc4;
   logic          ifu_i0_icaf;
   logic          ifu_fb_consume1;
   logic          ifu_fb_consume2;
   logic [2:0]    ifu_fb_count;

   modport master (
      output ifu_fetch_val, ifu_fetch_data, ifu_fetch_pc, ifu_fetch_hw_val,
             ifu_fetch_acc_err, exu_flush_final, dec_i0_decode_d,
      input  ifu_i0_valid, ifu_i0_instr, ifu_i0_pc, ifu_i0_pc4, ifu_i0_icaf,
             ifu_fb_consume1, ifu_fb_consume2, ifu_fb_count
   );

   modport slave (
      input  ifu_fetch_val, ifu_fetch_data, ifu_fetch_pc, ifu_fetch_hw_val,
             ifu_fetch_acc_err, exu_flush_final, dec_i0_decode_d,
      output ifu_i0_valid, ifu_i0_instr, ifu_i0_pc, ifu_i0_pc4, ifu_i0_icaf,
             ifu_fb_consume1, ifu_fb_consume2, ifu_fb_count
   );
endinterface

// File: rtl/el2_ifu_fb_aln.sv
// Four-entry fetch buffer and instruction aligner. Presents one 16/32-bit
// instruction per cycle (32-bit ones may straddle two packets) and reports
// freed entries on consume1/consume2 for fetch control's write model.
// Optional feature: define RV_FB_BYPASS_EN to present an instruction from an
// incoming packet in the same cycle when the buffer is empty.
module el2_ifu_fb_aln #(
   parameter int FB_DEPTH = 4
) (
   input logic              clk,
   input logic              rst_l,
   el2_ifu_fb_aln_if.slave  fb
);

   // Entry storage: data/pc/err are plain data, hwv carries occupancy state.
   logic [63:0] data_q [FB_DEPTH];
   logic [28:0] pc_q   [FB_DEPTH];
   logic [3:0]  hwv_q  [FB_DEPTH];
   logic        err_q  [FB_DEPTH];

   logic [1:0]  wp, rp, rp_n;
   logic [2:0]  cnt;

   function automatic logic [1:0] first_hw(input logic [3:0] m);
      first_hw = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) first_hw = 2'(i);
      end
   endfunction

   function automatic logic [15:0] hw_sel(input logic [63:0] d, input logic [1:0] idx);
      hw_sel = d[16*idx +: 16];
   endfunction

   logic        byp;
   logic [63:0] src_data;
   logic [28:0] src_pc;
   logic [3:0]  src_hwv;
   logic        src_err;
   logic [1:0]  off, off_n;
   logic [15:0] h0, h1;
   logic        is32, in_pkt, straddle;
   logic        valid_raw, valid, acc;
   logic [3:0]  clr_h, rem_h, next_rem;
   logic        free_h, free_n;
   logic [1:0]  freed;
   logic        wr_req, full, byp_done, wr_en;
   logic [3:0]  wr_hwv;
   logic        unused_pc_lo;

   assign rp_n = rp + 2'd1;

`ifdef RV_FB_BYPASS_EN
   assign byp = (cnt == 3'd0) & fb.ifu_fetch_val & ~fb.exu_flush_final;
`else
   assign byp = 1'b0;
`endif

   // Head source: incoming packet when bypassing, else the entry at rp.
   always_comb begin
      src_data = data_q[rp];
      src_pc   = pc_q[rp];
      src_hwv  = hwv_q[rp];
      src_err  = err_q[rp];
      if (byp) begin
         src_data = fb.ifu_fetch_data;
         src_pc   = fb.ifu_fetch_pc[30:2];
         src_hwv  = fb.ifu_fetch_hw_val;
         src_err  = fb.ifu_fetch_acc_err;
      end
   end

   assign off      = first_hw(src_hwv);
   assign off_n    = off + 2'd1;
   assign h0       = hw_sel(src_data, off);
   assign is32     = (h0[1:0] == 2'b11);
   assign in_pkt   = (off != 2'd3) & src_hwv[off_n];
   assign straddle = is32 & ~in_pkt & ~src_err;
   assign h1       = in_pkt ? hw_sel(src_data, off_n) : data_q[rp_n][15:0];

   // A straddling instruction needs the following entry; it is never bypassed.
   assign valid_raw = byp ? ~straddle
                          : (cnt != 3'd0) & (~straddle | (cnt >= 3'd2));
   assign valid     = valid_raw & ~fb.exu_flush_final;
   assign acc       = valid & fb.dec_i0_decode_d;

   assign clr_h    = src_err ? 4'hF
                   : ((4'b0001 << off) | ((is32 & in_pkt) ? (4'b0001 << off_n) : 4'b0000));
   assign rem_h    = src_hwv & ~clr_h;
   assign next_rem = hwv_q[rp_n] & 4'b1110;

   assign free_h = acc & ~byp & (rem_h == 4'h0);
   assign free_n = acc & ~byp & straddle & (next_rem == 4'h0);
   assign freed  = {1'b0, free_h} + {1'b0, free_n};

   assign wr_req   = fb.ifu_fetch_val & ~fb.exu_flush_final;
   assign full     = (cnt == 3'(FB_DEPTH)) & (freed == 2'd0);
   assign byp_done = byp & acc & (rem_h == 4'h0);
   assign wr_en    = wr_req & ~full & ~byp_done;
   assign wr_hwv   = (byp & acc) ? rem_h : fb.ifu_fetch_hw_val;

   assign unused_pc_lo = ^fb.ifu_fetch_pc[1:0];

   assign fb.ifu_i0_valid    = valid;
   assign fb.ifu_i0_instr    = (~valid | src_err) ? 32'h0
                             : (is32 ? {h1, h0} : {16'h0, h0});
   assign fb.ifu_i0_pc       = valid ? {src_pc, off} : 31'h0;
   assign fb.ifu_i0_pc4      = valid & ~src_err & is32;
   assign fb.ifu_i0_icaf     = valid & src_err;
   assign fb.ifu_fb_consume1 = free_h ^ free_n;
   assign fb.ifu_fb_consume2 = free_h & free_n;
   assign fb.ifu_fb_count    = cnt;

   // Control state: pointers, occupancy and per-entry valid-halfword masks.
   always_ff @(posedge clk) begin
      if (!rst_l || fb.exu_flush_final) begin
         wp  <= 2'd0;
         rp  <= 2'd0;
         cnt <= 3'd0;
         for (int i = 0; i < FB_DEPTH; i++) hwv_q[i] <= 4'h0;
      end else begin
         if (acc & ~byp) hwv_q[rp] <= rem_h;
         if (acc & ~byp & straddle) hwv_q[rp_n] <= next_rem;
         // A write into a just-freed slot must win over the clear above.
         if (wr_en) hwv_q[wp] <= wr_hwv;
         rp  <= rp + freed;
         wp  <= wp + {1'b0, wr_en};
         cnt <= cnt + {2'b00, wr_en} - {1'b0, freed};
      end
   end

   // Packet payload capture; occupancy is tracked by hwv so no reset needed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[wp] <= fb.ifu_fetch_data;
         pc_q[wp]   <= fb.ifu_fetch_pc[30:2];
         err_q[wp]  <= fb.ifu_fetch_acc_err;
      end
   end

endmodule

// File: tb/tb_el2_ifu_fb_aln.sv
// Directed bench for el2_ifu_fb_aln: alignment, straddling, full/drop,
// flush, access-fault entries, empty-buffer behaviour and mid-run reset.
module tb_el2_ifu_fb_aln;

   logic clk = 1'b0;
   logic rst_l;
   int   n_checks = 0;
   int   n_errors = 0;

   el2_ifu_fb_aln_if fb ();

   el2_ifu_fb_aln #(.FB_DEPTH(4)) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .fb    (fb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic [30:0] pc,
                        input logic [3:0] hv, input logic err, input logic fl,
                        input logic dec);
      fb.ifu_fetch_val     = v;
      fb.ifu_fetch_data    = d;
      fb.ifu_fetch_pc      = pc;
      fb.ifu_fetch_hw_val  = hv;
      fb.ifu_fetch_acc_err = err;
      fb.exu_flush_final   = fl;
      fb.dec_i0_decode_d   = dec;
      #1;
   endtask

   task automatic idle(input logic dec);
      drive(1'b0, 64'h0, 31'h0, 4'h0, 1'b0, 1'b0, dec);
   endtask

   logic [15:0] hw;

   initial begin
      // Reset state
      rst_l = 1'b0;
      idle(1'b0);
      tick;
      tick;
      check("rst_valid", fb.ifu_i0_valid, 0);
      check("rst_count", fb.ifu_fb_count, 0);
      check("rst_c1",    fb.ifu_fb_consume1, 0);
      check("rst_c2",    fb.ifu_fb_consume2, 0);
      check("rst_instr", fb.ifu_i0_instr, 0);
      check("rst_pc",    fb.ifu_i0_pc, 0);
      check("rst_pc4",   fb.ifu_i0_pc4, 0);
      check("rst_icaf",  fb.ifu_i0_icaf, 0);
      rst_l = 1'b1;

      // Packet A at 0x1000: 32-bit, 16-bit, then hw3 = 0x0013 needs a second packet
      drive(1'b1, 64'h0013_0001_4501_0513, 31'h800, 4'hF, 1'b0, 1'b0, 1'b0);
      check("a_cnt0", fb.ifu_fb_count, 0);
      tick;
      idle(1'b1);
      check("a1_valid", fb.ifu_i0_valid, 1);
      check("a1_instr", fb.ifu_i0_instr, 32'h4501_0513);
      check("a1_pc",    fb.ifu_i0_pc, 31'h800);
      check("a1_pc4",   fb.ifu_i0_pc4, 1);
      check("a1_cnt",   fb.ifu_fb_count, 1);
      tick;
      check("a2_instr", fb.ifu_i0_instr, 32'h0000_0001);
      check("a2_pc",    fb.ifu_i0_pc, 31'h802);
      check("a2_pc4",   fb.ifu_i0_pc4, 0);
      check("a2_c1",    fb.ifu_fb_consume1, 0);
      tick;
      // Packet B at 0x1008 with only hw0 valid arrives while head is stalled
      drive(1'b1, 64'hDEAD_BEEF_CAFE_0000, 31'h804, 4'h1, 1'b0, 1'b0, 1'b1);
      check("a3_stall_valid", fb.ifu_i0_valid, 0);
      tick;
      idle(1'b1);
      check("b_valid", fb.ifu_i0_valid, 1);
      check("b_cnt",   fb.ifu_fb_count, 2);
      check("b_instr", fb.ifu_i0_instr, 32'h0000_0013);
      check("b_pc",    fb.ifu_i0_pc, 31'h803);
      check("b_pc4",   fb.ifu_i0_pc4, 1);
      check("b_c2",    fb.ifu_fb_consume2, 1);
      check("b_c1",    fb.ifu_fb_consume1, 0);
      tick;
      check("b_cnt_after", fb.ifu_fb_count, 0);
      check("b_valid_after", fb.ifu_i0_valid, 0);

      // Fill four packets with decode stalled
      for (int k = 0; k < 4; k++) begin
         hw = 16'h0001 | 16'(k << 8);
         drive(1'b1, {4{hw}}, 31'h1800 + 31'(4 * k), 4'hF, 1'b0, 1'b0, 1'b0);
         tick;
      end
      idle(1'b0);
      check("full_cnt",   fb.ifu_fb_count, 4);
      check("full_instr", fb.ifu_i0_instr, 32'h0000_0001);
      check("full_pc",    fb.ifu_i0_pc, 31'h1800);
      drive(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 31'h2000, 4'hF, 1'b0, 1'b0, 1'b0);
      tick;
      idle(1'b0);
      check("drop_cnt",   fb.ifu_fb_count, 4);
      check("drop_instr", fb.ifu_i0_instr, 32'h0000_0001);
      for (int j = 0; j < 3; j++) begin
         idle(1'b1);
         check("drain_pc", fb.ifu_i0_pc, 31'h1800 + 31'(j));
         check("drain_c1", fb.ifu_fb_consume1, 0);
         tick;
      end
      drive(1'b1, {4{16'h0901}}, 31'h1810, 4'hF, 1'b0, 1'b0, 1'b1);
      check("wrfree_pc", fb.ifu_i0_pc, 31'h1803);
      check("wrfree_c1", fb.ifu_fb_consume1, 1);
      tick;
      idle(1'b0);
      check("wrfree_cnt",   fb.ifu_fb_count, 4);
      check("wrfree_pc2",   fb.ifu_i0_pc, 31'h1804);
      check("wrfree_instr", fb.ifu_i0_instr, 32'h0000_0101);

      // Flush with three entries plus a same-cycle write
      drive(1'b0, 64'h0, 31'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      tick;
      idle(1'b0);
      check("flush0_cnt", fb.ifu_fb_count, 0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, {4{16'h0005}}, 31'h2800 + 31'(4 * k), 4'hF, 1'b0, 1'b0, 1'b0);
         tick;
      end
      idle(1'b0);
      check("flush_pre_cnt", fb.ifu_fb_count, 3);
      drive(1'b1, {4{16'h0005}}, 31'h280C, 4'hF, 1'b0, 1'b1, 1'b1);
      check("flush_valid", fb.ifu_i0_valid, 0);
      check("flush_c1",    fb.ifu_fb_consume1, 0);
      check("flush_c2",    fb.ifu_fb_consume2, 0);
      tick;
      idle(1'b0);
      check("flush_cnt",    fb.ifu_fb_count, 0);
      check("flush_valid2", fb.ifu_i0_valid, 0);

      // Access-fault packet at 0x2000
      drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 31'h1000, 4'hF, 1'b1, 1'b0, 1'b0);
      tick;
      idle(1'b1);
      check("err_valid", fb.ifu_i0_valid, 1);
      check("err_icaf",  fb.ifu_i0_icaf, 1);
      check("err_instr", fb.ifu_i0_instr, 0);
      check("err_pc4",   fb.ifu_i0_pc4, 0);
      check("err_pc",    fb.ifu_i0_pc, 31'h1000);
      check("err_c1",    fb.ifu_fb_consume1, 1);
      check("err_c2",    fb.ifu_fb_consume2, 0);
      tick;
      check("err_cnt", fb.ifu_fb_count, 0);

      // Empty buffer, 16-bit instruction in hw3 of packet at 0x2006
      drive(1'b1, 64'h4085_0000_0000_0000, 31'h1003, 4'h8, 1'b0, 1'b0, 1'b1);
`ifdef RV_FB_BYPASS_EN
      check("byp_valid", fb.ifu_i0_valid, 1);
      check("byp_instr", fb.ifu_i0_instr, 32'h0000_4085);
      check("byp_pc",    fb.ifu_i0_pc, 31'h1003);
      check("byp_c1",    fb.ifu_fb_consume1, 0);
      check("byp_c2",    fb.ifu_fb_consume2, 0);
      tick;
      idle(1'b0);
      check("byp_cnt", fb.ifu_fb_count, 0);
      check("byp_valid2", fb.ifu_i0_valid, 0);
`else
      check("lat_valid", fb.ifu_i0_valid, 0);
      tick;
      idle(1'b1);
      check("lat_cnt",   fb.ifu_fb_count, 1);
      check("lat_valid2", fb.ifu_i0_valid, 1);
      check("lat_instr", fb.ifu_i0_instr, 32'h0000_4085);
      check("lat_pc",    fb.ifu_i0_pc, 31'h1003);
      check("lat_c1",    fb.ifu_fb_consume1, 1);
      tick;
      idle(1'b0);
      check("lat_cnt2", fb.ifu_fb_count, 0);
`endif

      // Reset mid-operation discards buffered entries
      drive(1'b1, {4{16'h0005}}, 31'h3000, 4'hF, 1'b0, 1'b0, 1'b0);
      tick;
      idle(1'b0);
      check("mid_pre_cnt", fb.ifu_fb_count, 1);
      rst_l = 1'b0;
      tick;
      rst_l = 1'b1;
      idle(1'b1);
      check("mid_rst_cnt",   fb.ifu_fb_count, 0);
      check("mid_rst_valid", fb.ifu_i0_valid, 0);
      check("mid_rst_c1",    fb.ifu_fb_consume1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
